// File: rtl/regfile_fault_injector.sv
// Command-side master for the register file CommandDataPort/StatePort: host bit flips and status probes,
// plus LFSR-driven flip campaigns when FAULT_INJ_CAMPAIGN_EN is defined.
module regfile_fault_injector #(
  parameter int unsigned CMD_WIDTH     = 8,
  parameter int unsigned D0_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter int unsigned PROBE_TIMEOUT = 1024,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter bit          SKIP_R0       = 1'b1,
  localparam int unsigned BIT_W        = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [4:0]            req_word_i,
  input  logic [BIT_W-1:0]      req_bit_i,
  input  logic [15:0]           req_count_i,
  input  logic [15:0]           req_interval_i,
  input  logic                  abort_i,
  output logic                  cmd_valid_o,
  output logic [CMD_WIDTH-1:0]  cmd_command_o,
  output logic [D0_WIDTH-1:0]   cmd_data0_o,
  output logic [DATA_WIDTH-1:0] cmd_data1_o,
  input  logic                  state0_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [15:0]           inj_count_o
);

  localparam logic [1:0]  OP_FLIP  = 2'd0;
  localparam logic [1:0]  OP_PROBE = 2'd1;
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(PROBE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_WAIT_ST
`ifdef FAULT_INJ_CAMPAIGN_EN
    , S_CWAIT
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             done_d, err_d;
  logic [15:0]      inj_d;
  logic             load;
  logic [4:0]       word_q;
  logic [BIT_W-1:0] bit_q;
  logic             flip_issue;

`ifdef FAULT_INJ_CAMPAIGN_EN
  localparam logic [1:0]  OP_CAMP  = 2'd2;
  localparam logic [15:0] MIN_DIST = 16'(GAP_CYCLES + 1);

  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] ival_q, ival_d;
  logic [4:0]  camp_word;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  assign camp_word  = (SKIP_R0 && (lfsr_q[4:0] == 5'd0)) ? 5'd1 : lfsr_q[4:0];
  assign flip_issue = (op_q == OP_FLIP) || (op_q == OP_CAMP);
`else
  logic unused_camp;
  assign unused_camp = ^{req_count_i, req_interval_i, LFSR_SEED, SKIP_R0};
  assign flip_issue  = (op_q == OP_FLIP);
`endif

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = ~req_ready_o;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    inj_d   = inj_count_o;
    load    = 1'b0;
`ifdef FAULT_INJ_CAMPAIGN_EN
    lfsr_d  = lfsr_q;
    rem_d   = rem_q;
    ival_d  = ival_q;
`endif
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (req_valid_i) begin
          load = 1'b1;
          op_d = req_op_i;
          case (req_op_i)
            OP_FLIP, OP_PROBE: state_d = S_ISSUE;
`ifdef FAULT_INJ_CAMPAIGN_EN
            OP_CAMP: begin
              rem_d  = req_count_i;
              // idle cycles beyond the forced gap so issues land exactly interval apart
              ival_d = (req_interval_i > MIN_DIST) ? (req_interval_i - MIN_DIST) : 16'd0;
              if (req_count_i == 16'd0) done_d = 1'b1;
              else                      state_d = S_ISSUE;
            end
`endif
            default: err_d = 1'b1;
          endcase
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_GAP;
        if (abort_i) abort_d = 1'b1;
        if (flip_issue && (inj_count_o != 16'hFFFF)) inj_d = inj_count_o + 16'd1;
`ifdef FAULT_INJ_CAMPAIGN_EN
        if (op_q == OP_CAMP) begin
          lfsr_d = lfsr_step(lfsr_q);
          rem_d  = rem_q - 16'd1;
        end
`endif
      end
      S_GAP: begin
        cnt_d = cnt_q + 16'd1;
        if (abort_i) abort_d = 1'b1;
        // an abort seen during issue/gap is honoured only once the gap has been served
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (abort_q || abort_i) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (op_q == OP_PROBE) begin
            state_d = S_WAIT_ST;
`ifdef FAULT_INJ_CAMPAIGN_EN
          end else if ((op_q == OP_CAMP) && (rem_q != 16'd0)) begin
            state_d = (ival_q == 16'd0) ? S_ISSUE : S_CWAIT;
`endif
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_ST: begin
        cnt_d = cnt_q + 16'd1;
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (state0_i) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
`ifdef FAULT_INJ_CAMPAIGN_EN
      S_CWAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (abort_i) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == ival_q - 16'd1) begin
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      op_q        <= OP_FLIP;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      inj_count_o <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      done_o      <= done_d;
      err_o       <= err_d;
      inj_count_o <= inj_d;
    end
  end

`ifdef FAULT_INJ_CAMPAIGN_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
      rem_q  <= '0;
      ival_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      rem_q  <= rem_d;
      ival_q <= ival_d;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (load) begin
      word_q <= req_word_i;
      bit_q  <= req_bit_i;
    end
  end

  // command fields stay zero outside the single issue cycle
  always_comb begin
    cmd_valid_o   = 1'b0;
    cmd_command_o = '0;
    cmd_data0_o   = '0;
    cmd_data1_o   = '0;
    if (state_q == S_ISSUE) begin
      cmd_valid_o = 1'b1;
      if (op_q == OP_PROBE) begin
        cmd_command_o = CMD_WIDTH'(2);
      end else begin
        cmd_command_o = CMD_WIDTH'(1);
        cmd_data0_o   = D0_WIDTH'(word_q);
        cmd_data1_o   = DATA_WIDTH'(bit_q);
`ifdef FAULT_INJ_CAMPAIGN_EN
        if (op_q == OP_CAMP) begin
          cmd_data0_o = D0_WIDTH'(camp_word);
          cmd_data1_o = DATA_WIDTH'(lfsr_q[8 +: BIT_W]);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_fault_injector.sv
// Randomized bench for regfile_fault_injector against a schedule-based reference model.
module tb_regfile_fault_injector;
  localparam int          GAP  = 2;
  localparam int          TMO  = 1024;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef FAULT_INJ_CAMPAIGN_EN
  localparam bit CAMP_EN = 1'b1;
`else
  localparam bit CAMP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [4:0]  req_word = 5'd0;
  logic [5:0]  req_bit = 6'd0;
  logic [15:0] req_count = 16'd0;
  logic [15:0] req_interval = 16'd0;
  logic        abort = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd_command;
  logic [31:0] cmd_data0;
  logic [63:0] cmd_data1;
  logic        state0 = 1'b0;
  logic        busy, done, err;
  logic [15:0] inj_count;

  always #5 clk = ~clk;

  regfile_fault_injector #(
    .CMD_WIDTH(8), .D0_WIDTH(32), .DATA_WIDTH(64), .GAP_CYCLES(GAP),
    .PROBE_TIMEOUT(TMO), .LFSR_SEED(SEED), .SKIP_R0(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_word_i(req_word), .req_bit_i(req_bit), .req_count_i(req_count),
    .req_interval_i(req_interval), .abort_i(abort),
    .cmd_valid_o(cmd_valid), .cmd_command_o(cmd_command),
    .cmd_data0_o(cmd_data0), .cmd_data1_o(cmd_data1), .state0_i(state0),
    .busy_o(busy), .done_o(done), .err_o(err), .inj_count_o(inj_count)
  );

  int          n_chk = 0;
  int          n_bad = 0;
  logic [15:0] m_inj = 16'd0;
  logic [15:0] m_lfsr = SEED;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack_out(input logic rdy, input logic bsy, input logic vld,
                                            input logic [7:0] cmd, input logic [31:0] d0,
                                            input logic [63:0] d1, input logic dn, input logic er);
    return {19'd0, rdy, bsy, vld, cmd, d0, d1, dn, er};
  endfunction

  function automatic logic [127:0] dut_out();
    return pack_out(req_ready, busy, cmd_valid, cmd_command, cmd_data0, cmd_data1, done, err);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Starts at a negedge with the DUT idle; returns at the negedge of the completion cycle.
  // Cycle t=1 is the cycle right after the accepting clock edge.
  task automatic run_op(input string name, input logic [1:0] op, input logic [4:0] word,
                        input logic [5:0] bt, input int count, input int interval,
                        input int rise_t, input int abort_t);
    int          iss_t[$];
    logic [7:0]  iss_c[$];
    logic [31:0] iss_d0[$];
    logic [63:0] iss_d1[$];
    logic [15:0] iss_lf[$];
    int          end_t, d, cut;
    bit          end_err, stays_idle;
    logic [15:0] l;
    logic [4:0]  w;
    logic        e_v;
    logic [7:0]  e_c;
    logic [31:0] e_d0;
    logic [63:0] e_d1;
    logic        e_busy;

    end_err = 1'b0;
    stays_idle = 1'b0;
    if (op == 2'd0) begin
      iss_t.push_back(1); iss_c.push_back(8'd1);
      iss_d0.push_back(32'(word)); iss_d1.push_back(64'(bt)); iss_lf.push_back(m_lfsr);
      end_t = GAP + 2;
    end else if (op == 2'd1) begin
      iss_t.push_back(1); iss_c.push_back(8'd2);
      iss_d0.push_back(32'd0); iss_d1.push_back(64'd0); iss_lf.push_back(m_lfsr);
      if (rise_t > 0) end_t = imax(rise_t, GAP + 2) + 1;
      else begin end_t = GAP + 2 + TMO; end_err = 1'b1; end
    end else if (op == 2'd2 && CAMP_EN) begin
      if (count == 0) begin
        end_t = 1; stays_idle = 1'b1;
      end else begin
        d = imax(interval, GAP + 1);
        l = m_lfsr;
        for (int k = 0; k < count; k++) begin
          w = (l[4:0] == 5'd0) ? 5'd1 : l[4:0];
          iss_t.push_back(1 + k * d); iss_c.push_back(8'd1);
          iss_d0.push_back(32'(w)); iss_d1.push_back(64'(l[13:8]));
          l = lfsr_next(l);
          iss_lf.push_back(l);
        end
        end_t = 1 + (count - 1) * d + GAP + 1;
      end
    end else begin
      end_t = 1; stays_idle = 1'b1; end_err = 1'b1;
    end

    if (abort_t > 0 && abort_t < end_t && !stays_idle) begin
      cut = -1;
      foreach (iss_t[i]) if (abort_t >= iss_t[i] && abort_t <= iss_t[i] + GAP) cut = i;
      if (cut >= 0) end_t = iss_t[cut] + GAP + 1;
      else          end_t = abort_t + 1;
      end_err = 1'b1;
      while (iss_t.size() > 0 && iss_t[iss_t.size()-1] >= end_t) begin
        void'(iss_t.pop_back()); void'(iss_c.pop_back());
        void'(iss_d0.pop_back()); void'(iss_d1.pop_back()); void'(iss_lf.pop_back());
      end
    end

    if (op != 2'd1) m_inj = m_inj + 16'(iss_t.size());
    if (op == 2'd2 && iss_lf.size() > 0) m_lfsr = iss_lf[iss_lf.size()-1];

    req_valid = 1'b1; req_op = op; req_word = word; req_bit = bt;
    req_count = 16'(count); req_interval = 16'(interval);
    @(posedge clk);
    for (int t = 1; t <= end_t; t++) begin
      @(negedge clk);
      e_v = 1'b0; e_c = 8'd0; e_d0 = 32'd0; e_d1 = 64'd0;
      foreach (iss_t[i]) if (iss_t[i] == t) begin
        e_v = 1'b1; e_c = iss_c[i]; e_d0 = iss_d0[i]; e_d1 = iss_d1[i];
      end
      e_busy = !stays_idle && (t < end_t);
      check_eq($sformatf("%s@%0d", name, t), dut_out(),
               pack_out(!e_busy, e_busy, e_v, e_c, e_d0, e_d1,
                        (t == end_t) && !end_err, (t == end_t) && end_err));
      if (t == 1) req_valid = 1'b0;
      state0 = (rise_t > 0) && (t >= rise_t);
      abort  = (abort_t == t);
    end
    check_eq({name, "_inj"}, {112'd0, inj_count}, {112'd0, m_inj});
    abort = 1'b0;
    state0 = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] op;
    int         sel;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_out", dut_out(), pack_out(1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 64'd0, 1'b0, 1'b0));
    check_eq("reset_inj", {112'd0, inj_count}, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("flip_w5_b17", 2'd0, 5'd5, 6'd17, 0, 0, 0, 0);
    run_op("probe_rise11", 2'd1, 5'd0, 6'd0, 0, 0, 11, 0);
    run_op("probe_early", 2'd1, 5'd3, 6'd9, 0, 0, 2, 0);
    run_op("probe_timeout", 2'd1, 5'd0, 6'd0, 0, 0, 0, 0);
    run_op("probe_abort", 2'd1, 5'd0, 6'd0, 0, 0, 0, GAP + 5);
    run_op("illegal_op", 2'd3, 5'd7, 6'd7, 0, 0, 0, 0);
    run_op("camp_4x5", 2'd2, 5'd0, 6'd0, 4, 5, 0, 0);
    run_op("camp_zero", 2'd2, 5'd0, 6'd0, 0, 5, 0, 0);
    run_op("camp_clamp", 2'd2, 5'd0, 6'd0, 3, 0, 0, 0);
    run_op("camp_abort", 2'd2, 5'd0, 6'd0, 100, 5, 0, 1 + 2 * 5);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_idle", dut_out(), pack_out(1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 64'd0, 1'b0, 1'b0));

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3)
        run_op("rnd_flip", 2'd0, 5'($urandom), 6'($urandom), 0, 0, 0, 0);
      else if (sel < 6)
        run_op("rnd_probe", 2'd1, 5'd0, 6'd0, 0, 0, $urandom_range(1, 20), 0);
      else if (sel < 9)
        run_op("rnd_camp", 2'd2, 5'd0, 6'd0, $urandom_range(0, 5), $urandom_range(0, 8), 0, 0);
      else
        run_op("rnd_illegal", 2'd3, 5'($urandom), 6'($urandom), 0, 0, 0, 0);
    end

    op = CAMP_EN ? 2'd2 : 2'd1;
    req_valid = 1'b1; req_op = op; req_count = 16'd100; req_interval = 16'd5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("pre_reset_vld", {127'd0, cmd_valid}, 128'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_out", dut_out(), pack_out(1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 64'd0, 1'b0, 1'b0));
    check_eq("async_reset_inj", {112'd0, inj_count}, 128'd0);
    m_inj = 16'd0;
    m_lfsr = SEED;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_reset_camp", 2'd2, 5'd0, 6'd0, 3, 4, 0, 0);
    run_op("post_reset_flip", 2'd0, 5'd31, 6'd63, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
